// File: rtl/gbf_flgofm_ctrl_if.sv
// Bundle of the upstream stream, downstream stream, RAM port and status signals for gbf_flgofm_ctrl.
// GBF_FLGOFM_STAT_EN adds the peak_occ status signal.
interface gbf_flgofm_ctrl_if #(
   parameter int SRAM_DEPTH_BIT = 6,
   parameter int SRAM_WIDTH     = 28
);
   logic                      in_vld;
   logic [SRAM_WIDTH-1:0]     in_dat;
   logic                      in_rdy;
   logic                      out_vld;
   logic [SRAM_WIDTH-1:0]     out_dat;
   logic                      out_rdy;
   logic [SRAM_DEPTH_BIT-1:0] ram_addr_w;
   logic [SRAM_DEPTH_BIT-1:0] ram_addr_r;
   logic                      ram_write_en;
   logic                      ram_read_en;
   logic [SRAM_WIDTH-1:0]     ram_data_in;
   logic [SRAM_WIDTH-1:0]     ram_data_out;
   logic [SRAM_DEPTH_BIT:0]   occupancy;
   logic                      empty;
   logic                      full;
`ifdef GBF_FLGOFM_STAT_EN
   logic [SRAM_DEPTH_BIT:0]   peak_occ;
`endif

   // master = the controller; slave = packer / output path / RAM wrapper side
   modport master (
      input  in_vld, in_dat, out_rdy, ram_data_out,
`ifdef GBF_FLGOFM_STAT_EN
      output peak_occ,
`endif
      output in_rdy, out_vld, out_dat, ram_addr_w, ram_addr_r, ram_write_en,
             ram_read_en, ram_data_in, occupancy, empty, full
   );

   modport slave (
      output in_vld, in_dat, out_rdy, ram_data_out,
`ifdef GBF_FLGOFM_STAT_EN
      input  peak_occ,
`endif
      input  in_rdy, out_vld, out_dat, ram_addr_w, ram_addr_r, ram_write_en,
             ram_read_en, ram_data_in, occupancy, empty, full
   );
endinterface

// File: rtl/gbf_flgofm_ctrl.sv
// FIFO controller in front of the single-port OFM flag RAM with a 2-entry read prefetch buffer.
// Optional GBF_FLGOFM_STAT_EN: peak_occ tracks the maximum occupancy since reset.
module gbf_flgofm_ctrl #(
   parameter int SRAM_DEPTH_BIT = 6,
   parameter int SRAM_WIDTH     = 28
) (
   input  logic                   clk,
   input  logic                   rst,
   gbf_flgofm_ctrl_if.master      bus
);
   localparam int DB = SRAM_DEPTH_BIT;
   localparam int W  = SRAM_WIDTH;
   localparam int OW = DB + 1;
   localparam logic [DB:0] DEPTH = {1'b1, {DB{1'b0}}};

   typedef enum logic {GRANT_READ = 1'b0, GRANT_WRITE = 1'b1} grant_t;

   logic [DB-1:0] wr_ptr;
   logic [DB-1:0] rd_ptr;
   logic [DB:0]   ram_cnt;
   logic [1:0]    buf_cnt;
   logic          rd_inflight;
   grant_t        last_grant;
   logic [W-1:0]  buf_q [2];

   logic          pop;
   logic [1:0]    buf_left;
   logic          read_want;
   logic          full;
   logic          in_rdy;
   logic          write_en;
   logic          read_en;

   always_comb begin
      pop      = (buf_cnt != 2'd0) & bus.out_rdy;
      buf_left = buf_cnt - {1'b0, pop};
      // Reserve a buffer slot for every read in flight so a capture never overflows
      read_want = (ram_cnt != '0) && ((buf_left + {1'b0, rd_inflight}) < 2'd2);
      full      = (ram_cnt == DEPTH);
      in_rdy    = ~rst & ~full & ~(read_want & (last_grant == GRANT_WRITE));
      write_en  = bus.in_vld & in_rdy;
      read_en   = read_want & ~write_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ram_cnt     <= '0;
         buf_cnt     <= 2'd0;
         rd_inflight <= 1'b0;
         last_grant  <= GRANT_READ;
         buf_q[0]    <= '0;
         buf_q[1]    <= '0;
      end else begin
         if (write_en) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_grant <= GRANT_WRITE;
         end
         if (read_en) begin
            rd_ptr     <= rd_ptr + 1'b1;
            last_grant <= GRANT_READ;
         end
         case ({write_en, read_en})
            2'b10:   ram_cnt <= ram_cnt + 1'b1;
            2'b01:   ram_cnt <= ram_cnt - 1'b1;
            default: ram_cnt <= ram_cnt;
         endcase
         rd_inflight <= read_en;
         if (pop) buf_q[0] <= buf_q[1];
         // Capture lands after the shift; a later NBA to the same slot wins
         if (rd_inflight) buf_q[buf_left[0]] <= bus.ram_data_out;
         buf_cnt <= buf_left + {1'b0, rd_inflight};
      end
   end

   always_comb begin
      bus.in_rdy       = in_rdy;
      bus.out_vld      = (buf_cnt != 2'd0);
      bus.out_dat      = buf_q[0];
      bus.ram_addr_w   = wr_ptr;
      bus.ram_addr_r   = rd_ptr;
      bus.ram_write_en = write_en;
      bus.ram_read_en  = read_en;
      bus.ram_data_in  = bus.in_dat;
      bus.occupancy    = ram_cnt + OW'(buf_cnt) + OW'(rd_inflight);
      bus.empty        = (bus.occupancy == '0);
      bus.full         = full;
   end

`ifdef GBF_FLGOFM_STAT_EN
   logic [DB:0] peak_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak_q <= '0;
      end else if (bus.occupancy > peak_q) begin
         peak_q <= bus.occupancy;
      end
   end

   assign bus.peak_occ = peak_q;
`endif
endmodule

// File: tb/tb_gbf_flgofm_ctrl.sv
// Randomized bench for gbf_flgofm_ctrl: RAM model plus an in-order word queue as reference.
module tb_gbf_flgofm_ctrl;
   logic clk;
   logic rst;
   int unsigned n_chk;
   int unsigned n_fail;
   int unsigned wr_n;
   int unsigned rd_n;
   int unsigned acc;
   logic [27:0] q[$];
   logic [27:0] mem [64];

   gbf_flgofm_ctrl_if #(.SRAM_DEPTH_BIT(6), .SRAM_WIDTH(28)) bus ();

   gbf_flgofm_ctrl #(.SRAM_DEPTH_BIT(6), .SRAM_WIDTH(28)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port RAM wrapper model, 1-cycle read latency
   always @(posedge clk) begin
      if (bus.ram_write_en) mem[bus.ram_addr_w] <= bus.ram_data_in;
      if (bus.ram_read_en) bus.ram_data_out <= mem[bus.ram_addr_r];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check and update the model before the next posedge
   task automatic cyc(input logic v, input logic [27:0] d, input logic r);
      @(negedge clk);
      bus.in_vld = v;
      bus.in_dat = d;
      bus.out_rdy = r;
      #1;
      chk("occupancy", 32'(bus.occupancy), q.size());
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("full", 32'(bus.full), 32'((wr_n - rd_n) == 64));
      chk("exclusive", 32'(bus.ram_write_en & bus.ram_read_en), 0);
      chk("write_en", 32'(bus.ram_write_en), 32'(v & bus.in_rdy));
      if (!bus.in_rdy) chk("stall_reason", 32'(bus.full | bus.ram_read_en), 1);
      if (bus.out_vld && r) begin
         if (q.size() == 0) chk("pop_empty", 1, 0);
         else begin
            chk("out_dat", 32'(bus.out_dat), 32'(q[0]));
            void'(q.pop_front());
         end
      end
      if (bus.ram_write_en) begin
         chk("ram_addr_w", 32'(bus.ram_addr_w), wr_n % 64);
         q.push_back(d);
         wr_n++;
         acc++;
      end
      if (bus.ram_read_en) begin
         chk("ram_addr_r", 32'(bus.ram_addr_r), rd_n % 64);
         rd_n++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_vld = 1'b1;
      bus.out_rdy = 1'b1;
      #1;
      chk("rst_out_vld", 32'(bus.out_vld), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_occ", 32'(bus.occupancy), 0);
      chk("rst_in_rdy", 32'(bus.in_rdy), 0);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_ren", 32'(bus.ram_read_en), 0);
      chk("rst_wen", 32'(bus.ram_write_en), 0);
      q.delete();
      wr_n = 0;
      rd_n = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus.in_vld = 1'b0;
      bus.out_rdy = 1'b0;
      #1;
      chk("rel_in_rdy", 32'(bus.in_rdy), 1);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         cyc(1'b0, '0, 1'b1);
         n++;
      end
      chk("drain_done", q.size(), 0);
   endtask

   initial begin
      int unsigned a0;
      int unsigned nxt;
      int n;
      n_chk = 0;
      n_fail = 0;
      wr_n = 0;
      rd_n = 0;
      acc = 0;
      rst = 1'b1;
      bus.in_vld = 1'b0;
      bus.in_dat = '0;
      bus.out_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset mid-burst
      for (int i = 0; i < 5; i++) cyc(1'b1, 28'($urandom), 1'b0);
      do_reset();

      // single word latency
      a0 = acc;
      cyc(1'b1, 28'h0ABCDEF, 1'b1);
      chk("t2_accept", acc - a0, 1);
      cyc(1'b0, '0, 1'b1);
      chk("t2_ren", 32'(bus.ram_read_en), 1);
      cyc(1'b0, '0, 1'b1);
      chk("t2_vld_early", 32'(bus.out_vld), 0);
      cyc(1'b0, '0, 1'b1);
      chk("t2_vld", 32'(bus.out_vld), 1);
      chk("t2_dat", 32'(bus.out_dat), 32'h0ABCDEF);
      drain();

      // fill: 64 in RAM + 2 prefetched
      a0 = acc;
      nxt = 0;
      for (int i = 0; i < 200; i++) begin
         cyc(nxt <= 66, 28'(nxt), 1'b0);
         if (acc - a0 > nxt) nxt++;
      end
      chk("t3_accepted", acc - a0, 66);
      chk("t3_occ", 32'(bus.occupancy), 66);
      chk("t3_full", 32'(bus.full), 1);
      chk("t3_in_rdy", 32'(bus.in_rdy), 0);
      drain();

      // wrap with random back-pressure
      a0 = acc;
      nxt = 0;
      n = 0;
      while (nxt < 100 && n < 2000) begin
         cyc(($urandom % 4) != 0, 28'(nxt), 1'($urandom % 2));
         if (acc - a0 > nxt) nxt++;
         n++;
      end
      chk("t4_pushed", nxt, 100);
      drain();
      chk("t4_wr_wrapped", 32'(wr_n > 64), 1);

      // contention: writes and reads alternate
      for (int k = 0; k < 60; k++) begin
         cyc(1'b1, 28'($urandom), 1'b1);
         chk("t5_wen", 32'(bus.ram_write_en), 32'(k % 2 == 0));
         chk("t5_ren", 32'(bus.ram_read_en), 32'(k % 2 == 1));
      end
      drain();

      // peak occupancy
      do_reset();
      a0 = acc;
      n = 0;
      while (acc - a0 < 10 && n < 100) begin
         cyc(1'b1, 28'($urandom), 1'b0);
         n++;
      end
      chk("t6_pushed", acc - a0, 10);
      drain();
      cyc(1'b0, '0, 1'b1);
      chk("t6_occ", 32'(bus.occupancy), 0);
`ifdef GBF_FLGOFM_STAT_EN
      chk("t6_peak", 32'(bus.peak_occ), 10);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
